bit_reader_512bits: RTL
=======================

BIT_READER_512BITS -- requirements
Module: bit_reader_512bits

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; single clock domain.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port: data_in  input  256  next packed word from memory; bit 0 is the oldest bit.
REQ-004 SHALL have port: data_valid  input  1  data_in holds a valid word.
REQ-005 SHALL have port: data_ready  output  1  block can accept data_in this cycle.
REQ-006 SHALL have port: consume  input  1  consumer removes bits this cycle.
REQ-007 SHALL have port: consume_len  input  8  bits removed when consume=1 (0..255).
REQ-008 SHALL have port: align  input  1  with consume, additionally skips to the next byte boundary.
REQ-009 SHALL have port: flush  input  1  synchronous discard of all buffered bits and alignment state.
REQ-010 SHALL have port: bits_out  output  256  unconsumed window; bit 0 is the oldest unconsumed bit.
REQ-011 SHALL have port: bits_avail  output  10  valid bits in the buffer (0..512).
REQ-012 SHALL have port: consume_err  output  1  one-cycle pulse: rejected consume request.

Function
REQ-013 SHALL hold a 512-bit register buf and a 10-bit register cnt, with valid bits in buf[cnt-1:0] and all bits above cnt at 0.
REQ-014 SHALL hold a 3-bit register pos = (total bits consumed since reset or flush) mod 8.
REQ-015 SHALL drive data_ready = (cnt <= 256) combinationally from registered cnt only; no dependence on consume.
REQ-016 SHALL perform a load when data_valid=1 and data_ready=1 at a rising edge (ld=1); data_in is not sampled otherwise.
REQ-017 SHALL compute pad = align ? ((8 - ((pos + consume_len) mod 8)) mod 8) : 0, and n = consume_len + pad (9-bit).
REQ-018 SHALL accept a consume request (acc=1) when consume=1 and n <= cnt; when consume=1 and n > cnt, acc=0 and consume_err=1 next cycle.
REQ-019 SHALL leave buf, cnt and pos unchanged by a rejected consume request.
REQ-020 SHALL, on acc=1, update buf <= buf >> n, cnt <= cnt - n, and pos <= (pos + n) mod 8.
REQ-021 SHALL, on ld=1 without acc, update buf <= buf | (data_in << cnt) and cnt <= cnt + 256.
REQ-022 SHALL, on ld=1 and acc=1 together, update buf <= (buf >> n) | (data_in << (cnt - n)) and cnt <= cnt - n + 256, with cnt never exceeding 512.
REQ-023 SHALL treat consume=1 with n=0 as accepted with no state change (no error).
REQ-024 SHALL drive bits_out = buf[255:0] and bits_avail = cnt, both registered, with 1-cycle latency from load or consume to visible window.
REQ-025 SHALL, on flush=1, set buf=0, cnt=0 and pos=0 at the next edge, overriding any load or consume in the same cycle; data_in is not accepted.
REQ-026 SHALL pulse consume_err for exactly one cycle per rejected request; its value is 0 otherwise.
REQ-027 SHALL ignore align when consume=0.

Reset
REQ-028 SHALL, while reset=0, asynchronously force buf=0, cnt=0, pos=0 and consume_err=0, giving bits_out=0, bits_avail=0 and data_ready=1.
REQ-029 SHALL, when reset asserts mid-operation, discard all buffered bits with no partial update; the first load is accepted on the first rising edge after reset=1.

Verification
REQ-030 Two loads A and B with no consume -> bits_avail 256 then 512, data_ready=0 at 512, bits_out=A[255:0].
REQ-031 At cnt=512: consume 200, then 56 -> cnt 312 then 256, data_ready=1, bits_out=B[255:0].
REQ-032 cnt=256 with load and consume_len=100 in the same cycle -> cnt=412, bits_out[155:0]=A[255:100], bits_out[255:156]=B[99:0].
REQ-033 pos=0: consume 3 with align=1 -> 8 bits removed, pos=0; consume 5 with align=0, then consume 0 with align=1 -> 3 bits removed.
REQ-034 cnt=10: consume 11 -> consume_err pulses 1 cycle, cnt stays 10; consume 10 -> cnt=0 with no error.
REQ-035 cnt=300 with flush, consume and load in the same cycle -> cnt=0, pos=0, no load; reset=0 mid-stream -> all outputs 0 immediately, data_ready=1.

Source files
------------

// File: rtl/bit_reader_512bits.sv
// Bit-granular reader over a 512-bit buffer fed by 256-bit packed words.
// Oldest bit sits at bit 0; consumers remove 0..255 bits per cycle.
module bit_reader_512bits (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic         consume,
  input  logic [7:0]   consume_len,
  input  logic         align,
  input  logic         flush,
  output logic [255:0] bits_out,
  output logic [9:0]   bits_avail,
  output logic         consume_err
);

  logic [511:0] buf_q;
  logic [511:0] buf_d;
  logic [9:0]   cnt_q;
  logic [9:0]   cnt_d;
  logic [9:0]   base;
  logic [2:0]   pos_q;
  logic [2:0]   pos_d;
  logic [2:0]   mis;
  logic [2:0]   pad;
  logic [8:0]   n;
  logic         err_q;
  logic         ld;
  logic         acc;

  // Padding to the next byte boundary is the 3-bit negation of the misalignment.
  assign mis = pos_q + consume_len[2:0];
  assign pad = align ? (3'd0 - mis) : 3'd0;
  assign n   = {1'b0, consume_len} + {6'd0, pad};

  assign data_ready = (cnt_q <= 10'd256);
  assign ld         = data_valid & data_ready & ~flush;
  assign acc        = consume & ({1'b0, n} <= cnt_q);

  always_comb begin
    buf_d = buf_q;
    base  = cnt_q;
    pos_d = pos_q;
    if (acc) begin
      buf_d = buf_q >> n;
      base  = cnt_q - {1'b0, n};
      pos_d = pos_q + n[2:0];
    end
    cnt_d = base;
    // Loads are only taken at cnt <= 256, so the sum never passes 512.
    if (ld) begin
      buf_d = buf_d | ({256'd0, data_in} << base);
      cnt_d = base + 10'd256;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
      cnt_q <= '0;
      pos_q <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      buf_q <= '0;
      cnt_q <= '0;
      pos_q <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      err_q <= consume & ~acc;
    end
  end

  assign bits_out    = buf_q[255:0];
  assign bits_avail  = cnt_q;
  assign consume_err = err_q;

endmodule
